// File: rtl/tone_pkg.sv
// Shared types, note frequency table and half-period helper for the note tone generator.
package tone_pkg;

    typedef enum logic [1:0] {StIdle, StPlay, StSustain} tone_state_e;

    // bit3 = octave (1 = med), [2:0] = scale degree 1..7, 0 = no note
    typedef logic [3:0] note_code_t;

    localparam int unsigned NoteFreq [2][7] = '{
        '{262, 294, 330, 349, 392, 440, 494},
        '{523, 587, 659, 698, 784, 880, 988}
    };

    function automatic int unsigned half_period(input int unsigned freq, input int unsigned clk_hz);
        return (clk_hz + freq) / (2 * freq);
    endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Keypad-code inputs and buzzer-side outputs of the note tone generator.
interface note_tone_gen_if;
    import tone_pkg::*;

    logic [3:0] med;
    logic [3:0] low;
    logic       buzzer;
    logic       playing;
    note_code_t cur_note;

    modport master (output med, output low, input buzzer, input playing, input cur_note);
    modport slave  (input med, input low, output buzzer, output playing, output cur_note);

endinterface

// File: rtl/note_code_sync.sv
// Two-flop synchroniser, med-over-low priority decode and stability filter producing cmt.
module note_code_sync
    import tone_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] med,
    input  logic [3:0] low,
    output note_code_t cmt
);

    localparam int unsigned CntW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYC - 1);

    logic [7:0]      sync1_q, sync2_q;
    logic [3:0]      med_s, low_s;
    note_code_t      code, prev_q, cmt_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign med_s = sync2_q[7:4];
    assign low_s = sync2_q[3:0];

    // Codes 8..15 carry bit3 set and count as no note.
    always_comb begin
        code = '0;
        if (!med_s[3] && med_s[2:0] != 3'd0) begin
            code = {1'b1, med_s[2:0]};
        end else if (!low_s[3] && low_s[2:0] != 3'd0) begin
            code = {1'b0, low_s[2:0]};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (code != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntLast) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            cmt_q   <= '0;
        end else begin
            sync1_q <= {med, low};
            sync2_q <= sync1_q;
            prev_q  <= code;
            cnt_q   <= cnt_d;
            if (cnt_d == CntLast) begin
                cmt_q <= code;
            end
        end
    end

    assign cmt = cmt_q;

endmodule

// File: rtl/note_tone_gen.sv
// Keypad note code to glitch-free piezo square wave; pitch changes only on half-period boundaries.
// Optional release sustain enabled by defining TONE_SUSTAIN_EN.
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned STABLE_CYC  = 1000,
    parameter int unsigned SUSTAIN_CYC = 5_000_000
) (
    input logic            clk,
    input logic            rst_n,
    note_tone_gen_if.slave bus
);

    if (CNT_W < $clog2(half_period(262, CLK_HZ) + 1)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the lowest note");
    end
    if (SUSTAIN_CYC == 0) begin : g_bad_sustain
        $error("SUSTAIN_CYC must be nonzero");
    end

    note_code_t cmt;

    note_code_sync #(
        .STABLE_CYC(STABLE_CYC)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .med  (bus.med),
        .low  (bus.low),
        .cmt  (cmt)
    );

    // Half-period minus one per note code; entries 0 and 8 are never selected while sounding.
    logic [CNT_W-1:0] half_m1_tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_half
        if ((i % 8) == 0) begin : g_unused
            assign half_m1_tab[i] = '0;
        end else begin : g_note
            assign half_m1_tab[i] =
                CNT_W'(half_period(NoteFreq[i / 8][(i % 8) - 1], CLK_HZ) - 1);
        end
    end

    tone_state_e      state_q;
    logic [CNT_W-1:0] phase_q;
    logic             buzzer_q;
    logic             playing_q;
    note_code_t       active_q;
    note_code_t       cur_note_q;
    logic             boundary;

`ifdef TONE_SUSTAIN_EN
    localparam int unsigned SusW = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
    localparam logic [SusW-1:0] SusLast = SusW'(SUSTAIN_CYC - 1);
    logic [SusW-1:0] sus_q;
`endif

    assign boundary = (phase_q >= half_m1_tab[active_q]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            buzzer_q   <= 1'b0;
            playing_q  <= 1'b0;
            active_q   <= '0;
            cur_note_q <= '0;
`ifdef TONE_SUSTAIN_EN
            sus_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    phase_q    <= '0;
                    buzzer_q   <= 1'b0;
                    cur_note_q <= '0;
                    if (cmt != '0) begin
                        state_q    <= StPlay;
                        playing_q  <= 1'b1;
                        buzzer_q   <= 1'b1;
                        active_q   <= cmt;
                        cur_note_q <= cmt;
                    end
                end
                StPlay: begin
                    if (!boundary) begin
                        phase_q <= phase_q + 1'b1;
                    end else begin
                        phase_q  <= '0;
                        buzzer_q <= ~buzzer_q;
                        if (cmt != '0 && cmt != active_q) begin
                            active_q   <= cmt;
                            cur_note_q <= cmt;
                        end
                    end
`ifdef TONE_SUSTAIN_EN
                    if (cmt == '0) begin
                        state_q <= StSustain;
                        sus_q   <= '0;
                    end
`else
                    // Only a falling toggle ends the tone, so the last period is always complete.
                    if (boundary && cmt == '0 && buzzer_q) begin
                        state_q    <= StIdle;
                        playing_q  <= 1'b0;
                        cur_note_q <= '0;
                    end
`endif
                end
`ifdef TONE_SUSTAIN_EN
                StSustain: begin
                    if (sus_q != SusLast) begin
                        sus_q <= sus_q + 1'b1;
                    end
                    if (cmt != '0) begin
                        state_q <= StPlay;
                    end
                    if (!boundary) begin
                        phase_q <= phase_q + 1'b1;
                    end else begin
                        phase_q  <= '0;
                        buzzer_q <= ~buzzer_q;
                    end
                    if (boundary && cmt == '0 && sus_q == SusLast && buzzer_q) begin
                        state_q    <= StIdle;
                        playing_q  <= 1'b0;
                        cur_note_q <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.buzzer   = buzzer_q;
    assign bus.playing  = playing_q;
    assign bus.cur_note = cur_note_q;

endmodule
